// File: rtl/ram_pkg.sv
// Shared sizing constants for the ram block and its storage array.
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 32;
  localparam int RAM_ADDR_WIDTH = 5;

  function automatic int ram_depth(input int aw);
    return 1 << aw;
  endfunction

  localparam int RAM_DEPTH = ram_depth(RAM_ADDR_WIDTH);

endpackage

// File: rtl/ram_array.sv
// Word storage with one write port and a combinational read of mem[addr].
// Defining RAM_CLEAR_ON_RESET_EN makes reset_n clear every word asynchronously.
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = ram_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef RAM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= din;
    end
  end
`else
  // Contents survive reset; a write on an edge with reset_n low is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && we) mem[addr] <= din;
  end
`endif

  assign rdata = mem[addr];

endmodule

// File: rtl/ram.sv
// Single-port RAM top: cen/wen decode and the registered read output dout.
// Optional build macro RAM_CLEAR_ON_RESET_EN clears storage on reset.
module ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rdata;

  assign we = cen & wen;
  assign re = cen & ~wen;

  ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .rdata  (rdata)
  );

  // Read data stage: only a read edge presents data, every other edge zeroes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
    end else if (re) begin
      dout <= rdata;
    end else begin
      dout <= '0;
    end
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed scenarios then random traffic against a word-array model.
module tb_ram;

  logic        clk;
  logic        reset_n;
  logic        cen;
  logic        wen;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  int checks;
  int errors;

  logic [31:0] model_mem   [32];
  bit          model_known [32];
  logic [31:0] exp_dout;
  bit          exp_known;

  ram #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cen    (cen),
    .wen    (wen),
    .addr   (addr),
    .din    (din),
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_dout  = '0;
    exp_known = 1'b1;
`ifdef RAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 32; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b1;
    end
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input string tag, input logic c, input logic w,
                     input logic [4:0] a, input logic [31:0] d);
    cen  = c;
    wen  = w;
    addr = a;
    din  = d;
    @(posedge clk);
    if (!reset_n) begin
      exp_dout  = '0;
      exp_known = 1'b1;
    end else if (c && w) begin
      model_mem[a]   = d;
      model_known[a] = 1'b1;
      exp_dout       = '0;
      exp_known      = 1'b1;
    end else if (c) begin
      exp_dout  = model_mem[a];
      exp_known = model_known[a];
    end else begin
      exp_dout  = '0;
      exp_known = 1'b1;
    end
    #1;
    if (exp_known) chk(tag, dout, exp_dout);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cen       = 1'b0;
    wen       = 1'b0;
    addr      = '0;
    din       = '0;
    exp_dout  = '0;
    exp_known = 1'b1;
    for (int i = 0; i < 32; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b0;
    end

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    #1 chk("reset_async", dout, 32'h0);
    cyc("reset_hold", 1'b0, 1'b0, 5'd0, 32'h0);
    cyc("reset_hold", 1'b0, 1'b0, 5'd0, 32'h0);
    #2 reset_n = 1'b1;

    for (int n = 0; n < 32; n++) cyc("sweep_wr", 1'b1, 1'b1, 5'(n), 32'(n));
    for (int n = 0; n < 32; n++) cyc("sweep_rd", 1'b1, 1'b0, 5'(n), 32'(n));

    cyc("idle", 1'b0, 1'b1, 5'd7, 32'hFFFF_FFFF);
    cyc("idle_rd7", 1'b1, 1'b0, 5'd7, 32'h0);

    cyc("rd5", 1'b1, 1'b0, 5'd5, 32'h0);
    cyc("wr_cycle", 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
    cyc("rd3_after_wr", 1'b1, 1'b0, 5'd3, 32'h0);

    cyc("rd9", 1'b1, 1'b0, 5'd9, 32'h0);
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk("rst_mid_read", dout, 32'h0);
    cyc("wr_in_rst", 1'b1, 1'b1, 5'd4, 32'h1234);
    #2 reset_n = 1'b1;
    cyc("rd9_after_rst", 1'b1, 1'b0, 5'd9, 32'h0);
    cyc("rd4_after_rst", 1'b1, 1'b0, 5'd4, 32'h0);

    cyc("ow_a", 1'b1, 1'b1, 5'd31, 32'hA);
    cyc("ow_b", 1'b1, 1'b1, 5'd31, 32'hB);
    cyc("ow_rd", 1'b1, 1'b0, 5'd31, 32'h0);

    for (int k = 0; k < 400; k++) begin
      cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), $urandom);
    end

    for (int n = 0; n < 32; n++) cyc("final_rd", 1'b1, 1'b0, 5'(n), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
